fma_seq_unit: RTL and testbench



---
 rtl/fma_seq_unit.sv | 133 +++++++++++++
 tb/tb_fma_seq_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fma_seq_unit.sv
// Sequential unsigned fused multiply-add (a*b + c) driven from PIO output registers.
// Define FMA_SEQ_OPCOUNT_EN to build the wrapping completed-operation counter on op_count.
module fma_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     op_c,
    input  logic [7:0]           ctrl,
    output logic [2*WIDTH-1:0]   result,
    output logic [7:0]           status,
    output logic [7:0]           op_count
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_startD;
    logic                 r_clrD;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_addend;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;

    logic                 w_startEvt;
    logic                 w_clrEvt;
    logic                 w_unusedCtrl;

    // Edge detectors reset high so the PIO's 0x0F reset value cannot fire an event.
    assign w_startEvt   = ctrl[0] & ~r_startD;
    assign w_clrEvt     = ctrl[1] & ~r_clrD;
    assign w_unusedCtrl = ^ctrl[7:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_startD  <= 1'b1;
            r_clrD    <= 1'b1;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_addend  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_startD <= ctrl[0];
            r_clrD   <= ctrl[1];

            if (w_clrEvt) begin
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_startEvt && r_busy) begin
                r_overrun <= 1'b1;
            end

            // Later assignments below take priority, so completion beats a same-edge clear.
            case (r_state)
                IDLE: begin
                    if (w_startEvt) begin
                        r_mcand  <= {{WIDTH{1'b0}}, op_a};
                        r_mplier <= op_b;
                        r_addend <= op_c;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_result <= r_acc + {{WIDTH{1'b0}}, r_addend};
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FMA_SEQ_OPCOUNT_EN
    logic [7:0] r_opCount;

    // Counts completions only; a clear event leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opCount <= '0;
        end else if (r_state == ADD) begin
            r_opCount <= r_opCount + 8'd1;
        end
    end

    assign op_count = r_opCount;
`else
    assign op_count = 8'd0;
`endif

    assign result = r_result;
    assign status = {5'b00000, r_overrun, r_done, r_busy};

endmodule

// File: tb/tb_fma_seq_unit.sv
// Directed self-checking bench for fma_seq_unit (WIDTH=8).
// Expected op_count follows FMA_SEQ_OPCOUNT_EN so the bench suits either build.
module tb_fma_seq_unit;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   opC;
    logic [7:0]         ctrl;
    logic [2*WIDTH-1:0] result;
    logic [7:0]         status;
    logic [7:0]         opCount;

    int compareCount  = 0;
    int mismatchCount = 0;
    int expOpCount    = 0;

    fma_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_a     (opA),
        .op_b     (opB),
        .op_c     (opC),
        .ctrl     (ctrl),
        .result   (result),
        .status   (status),
        .op_count (opCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectedOpCount();
`ifdef FMA_SEQ_OPCOUNT_EN
        return expOpCount[7:0];
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] ctl);
        opA  = a;
        opB  = b;
        opC  = c;
        ctrl = ctl;
    endtask

    // Leaves ctrl[0] rising so that the next clock edge is the start edge E0.
    task automatic armStart(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        applyStimulus(a, b, c, 8'h00);
        tick();
        applyStimulus(a, b, c, 8'h01);
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [15:0] expected);
        armStart(a, b, c);
        tick();
        checkOutput({tag, "-busyAtE0"}, 32'(status[1:0]), 32'h1);
        repeat (8) tick();
        checkOutput({tag, "-notDoneAtE8"}, 32'(status[1:0]), 32'h1);
        tick();
        expOpCount++;
        checkOutput({tag, "-doneAtE9"}, 32'(status[1:0]), 32'h2);
        checkOutput({tag, "-result"}, 32'(result), 32'(expected));
        checkOutput({tag, "-opCount"}, 32'(opCount), 32'(expectedOpCount()));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h0F);
        repeat (3) tick();
        checkOutput("inReset-status", 32'(status), 32'h0);
        checkOutput("inReset-result", 32'(result), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("postReset-status", 32'(status), 32'h0);
            checkOutput("postReset-result", 32'(result), 32'h0);
            checkOutput("postReset-opCount", 32'(opCount), 32'h0);
        end

        // 12*10+7
        runOp("basic", 8'd12, 8'd10, 8'd7, 16'd127);
        checkOutput("basic-status", 32'(status), 32'h02);

        // Maximum operands, with PIO values changed mid-run
        armStart(8'd255, 8'd255, 8'd255);
        tick();
        repeat (3) tick();
        applyStimulus(8'd1, 8'd1, 8'd1, 8'h01);
        checkOutput("max-resultHeldE3", 32'(result), 32'd127);
        repeat (5) tick();
        checkOutput("max-resultHeldE8", 32'(result), 32'd127);
        tick();
        expOpCount++;
        checkOutput("max-status", 32'(status), 32'h02);
        checkOutput("max-result", 32'(result), 32'hFF00);
        checkOutput("max-opCount", 32'(opCount), 32'(expectedOpCount()));

        // Second start 3 cycles into an operation
        armStart(8'd3, 8'd5, 8'd1);
        tick();
        tick();
        applyStimulus(8'd3, 8'd5, 8'd1, 8'h00);
        tick();
        applyStimulus(8'd3, 8'd5, 8'd1, 8'h01);
        tick();
        checkOutput("overrun-statusE3", 32'(status), 32'h05);
        repeat (5) tick();
        tick();
        expOpCount++;
        checkOutput("overrun-status", 32'(status), 32'h06);
        checkOutput("overrun-result", 32'(result), 32'd16);
        repeat (3) tick();
        checkOutput("overrun-singleDone", 32'(status), 32'h06);
        checkOutput("overrun-opCount", 32'(opCount), 32'(expectedOpCount()));
        applyStimulus(8'd3, 8'd5, 8'd1, 8'h02);
        tick();
        checkOutput("clear-status", 32'(status), 32'h00);
        checkOutput("clear-result", 32'(result), 32'd16);

        runOp("zeroA", 8'd0, 8'd200, 8'd9, 16'd9);
        runOp("zeroB", 8'd200, 8'd0, 8'd0, 16'd0);

        // Reset in the middle of an operation
        armStart(8'd7, 8'd9, 8'd2);
        tick();
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        expOpCount = 0;
        checkOutput("midReset-result", 32'(result), 32'h0);
        checkOutput("midReset-status", 32'(status), 32'h0);
        checkOutput("midReset-opCount", 32'(opCount), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("midReset-noSpuriousStart", 32'(status), 32'h0);
        runOp("afterReset", 8'd7, 8'd9, 8'd2, 16'd65);

        // Clear arriving on the completion edge
        armStart(8'd2, 8'd3, 8'd4);
        tick();
        repeat (8) tick();
        applyStimulus(8'd2, 8'd3, 8'd4, 8'h03);
        tick();
        expOpCount++;
        checkOutput("clrOnDone-status", 32'(status), 32'h02);
        checkOutput("clrOnDone-result", 32'(result), 32'd10);

        // Start arriving on the completion edge
        armStart(8'd5, 8'd6, 8'd1);
        tick();
        repeat (7) tick();
        applyStimulus(8'd5, 8'd6, 8'd1, 8'h00);
        tick();
        applyStimulus(8'd5, 8'd6, 8'd1, 8'h01);
        tick();
        expOpCount++;
        checkOutput("startOnDone-status", 32'(status), 32'h06);
        checkOutput("startOnDone-result", 32'(result), 32'd31);
        repeat (2) tick();
        checkOutput("startOnDone-noNewOp", 32'(status), 32'h06);

        // Clear and start together while idle
        applyStimulus(8'd4, 8'd4, 8'd4, 8'h00);
        tick();
        applyStimulus(8'd4, 8'd4, 8'd4, 8'h03);
        tick();
        checkOutput("clrStart-statusE0", 32'(status), 32'h01);
        repeat (8) tick();
        tick();
        expOpCount++;
        checkOutput("clrStart-status", 32'(status), 32'h02);
        checkOutput("clrStart-result", 32'(result), 32'd20);
        checkOutput("clrStart-opCount", 32'(opCount), 32'(expectedOpCount()));

`ifdef FMA_SEQ_OPCOUNT_EN
        reset_n = 1'b0;
        #1;
        expOpCount = 0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            runOp("wrap", 8'(i), 8'd3, 8'd1, 16'(((i % 256) * 3) + 1));
        end
        checkOutput("wrap-final", 32'(opCount), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
